// File: rtl/block_memory.sv
// Line-granular main-memory model with configurable access latency.
// Serves one whole cache line per request and holds busywait until the array access is done.
module block_memory #(
    parameter int DATA_WIDTH       = 32,
    parameter int WORDS_PER_BLOCK  = 4,
    parameter int BLOCK_ADDR_WIDTH = 14,
    parameter int LATENCY          = 5
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    input  logic [BLOCK_ADDR_WIDTH-1:0]           mem_address,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_writedata,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_readdata,
    output logic                                  mem_busywait
);

    localparam int LINE_W = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int DEPTH  = 1 << BLOCK_ADDR_WIDTH;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_is_write;
    logic [BLOCK_ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_W-1:0]             r_wdata;
    logic [LINE_W-1:0]             r_rdata;
    logic [LINE_W-1:0]             r_mem [0:DEPTH-1];

    logic w_req;
    logic w_commit;

    assign w_req    = mem_read | mem_write;
    assign w_commit = (r_state == S_ACCESS) && (r_cnt == '0);

    // Busywait is gated by reset so it drops the instant reset asserts, even with a request held.
    assign mem_busywait = reset_n & (((r_state == S_IDLE) & w_req) | (r_state == S_ACCESS));
    assign mem_readdata = r_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_write <= mem_write;
                        r_addr     <= mem_address;
                        r_wdata    <= mem_writedata;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_commit) begin
                        if (!r_is_write)
                            r_rdata <= r_mem[r_addr];
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; an aborted access never reaches the commit edge, so nothing is written.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write)
            r_mem[r_addr] <= r_wdata;
    end

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory: directed scenarios plus a randomized
// read/write mix against an associative-array memory model.
module tb_block_memory;

    localparam int DW  = 32;
    localparam int WPB = 4;
    localparam int AW  = 14;
    localparam int LAT = 5;
    localparam int LW  = DW * WPB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [LW-1:0] mem_writedata = '0;
    logic [LW-1:0] mem_readdata;
    logic          mem_busywait;

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] model [int];
    logic [LW-1:0] last_rd = '0;

    block_memory #(
        .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB), .BLOCK_ADDR_WIDTH(AW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one request from #1 after an edge; returns busy cycle count and readdata seen in the response cycle.
    task automatic xfer(input bit wr, input bit both, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, output int busy, output logic [LW-1:0] rd);
        mem_address   = a;
        mem_writedata = d;
        mem_write     = wr | both;
        mem_read      = !wr | both;
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!mem_busywait) break;
            busy++;
            @(posedge clk); #1;
        end
        rd = mem_readdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        if (wr | both) model[int'(a)] = d;
        else if (model.exists(int'(a))) last_rd = model[int'(a)];
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (mem_busywait !== 1'b0) begin
                bad++; $display("FAIL reset_idle_busy cycle %0d got=%b exp=0", c, mem_busywait);
            end
            total++;
            if (mem_readdata !== '0) begin
                bad++; $display("FAIL reset_idle_rdata cycle %0d got=%h exp=0", c, mem_readdata);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int busy; logic [LW-1:0] rd; logic [LW-1:0] ln;
        ln = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        xfer(1'b1, 1'b0, 14'h0012, ln, busy, rd);
        total++;
        if (busy !== LAT + 1) begin bad++; $display("FAIL write_busy got=%0d exp=%0d", busy, LAT + 1); end
        total++;
        if (rd !== last_rd) begin bad++; $display("FAIL write_rdata_held got=%h exp=%h", rd, last_rd); end
        @(negedge clk);
        total++;
        if (mem_busywait !== 1'b0) begin bad++; $display("FAIL write_idle_after got=%b exp=0", mem_busywait); end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int busy; logic [LW-1:0] rd;
        xfer(1'b0, 1'b0, 14'h0012, '0, busy, rd);
        total++;
        if (busy !== LAT + 1) begin bad++; $display("FAIL read_busy got=%0d exp=%0d", busy, LAT + 1); end
        total++;
        if (rd !== model[32'h12]) begin bad++; $display("FAIL read_line got=%h exp=%h", rd, model[32'h12]); end
        total++;
        if (rd[DW-1:0] !== 32'hAAAA0000) begin bad++; $display("FAIL read_word0 got=%h exp=AAAA0000", rd[DW-1:0]); end
    endtask

    task automatic test_both_top();
        int busy; logic [LW-1:0] rd; logic [LW-1:0] d0, dt;
        d0 = rnd_line();
        dt = rnd_line();
        xfer(1'b1, 1'b0, 14'h0000, d0, busy, rd);
        xfer(1'b0, 1'b1, 14'h3FFF, dt, busy, rd);
        total++;
        if (busy !== LAT + 1) begin bad++; $display("FAIL both_busy got=%0d exp=%0d", busy, LAT + 1); end
        total++;
        if (rd !== last_rd) begin bad++; $display("FAIL both_is_write got=%h exp=%h", rd, last_rd); end
        xfer(1'b0, 1'b0, 14'h3FFF, '0, busy, rd);
        total++;
        if (rd !== dt) begin bad++; $display("FAIL top_read got=%h exp=%h", rd, dt); end
        xfer(1'b0, 1'b0, 14'h0000, '0, busy, rd);
        total++;
        if (rd !== d0) begin bad++; $display("FAIL block0_no_alias got=%h exp=%h", rd, d0); end
    endtask

    task automatic test_latch();
        int busy; logic [LW-1:0] rd; logic [LW-1:0] da, db, dn;
        da = rnd_line(); db = rnd_line(); dn = rnd_line();
        xfer(1'b1, 1'b0, 14'h0100, da, busy, rd);
        xfer(1'b1, 1'b0, 14'h0200, db, busy, rd);
        mem_address = 14'h0100; mem_writedata = dn; mem_write = 1'b1;
        @(posedge clk); #1;
        mem_address = 14'h0200; mem_writedata = rnd_line();
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!mem_busywait) break;
            busy++;
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== LAT) begin bad++; $display("FAIL latch_busy got=%0d exp=%0d", busy, LAT); end
        model[32'h100] = dn;
        xfer(1'b0, 1'b0, 14'h0200, '0, busy, rd);
        total++;
        if (rd !== db) begin bad++; $display("FAIL latch_new_addr_untouched got=%h exp=%h", rd, db); end
        xfer(1'b0, 1'b0, 14'h0100, '0, busy, rd);
        total++;
        if (rd !== dn) begin bad++; $display("FAIL latch_old_addr_written got=%h exp=%h", rd, dn); end
    endtask

    task automatic test_reset_abort();
        int busy; logic [LW-1:0] rd; logic [LW-1:0] p;
        p = rnd_line();
        xfer(1'b1, 1'b0, 14'h0007, p, busy, rd);
        xfer(1'b0, 1'b0, 14'h0007, '0, busy, rd);
        mem_address = 14'h0007; mem_writedata = {4{32'h11111111}}; mem_write = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (mem_busywait !== 1'b0) begin bad++; $display("FAIL abort_busy_async got=%b exp=0", mem_busywait); end
        total++;
        if (mem_readdata !== '0) begin bad++; $display("FAIL abort_rdata_async got=%h exp=0", mem_readdata); end
        last_rd = '0;
        repeat (2) @(posedge clk);
        mem_write = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (mem_busywait !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", mem_busywait); end
        xfer(1'b0, 1'b0, 14'h0007, '0, busy, rd);
        total++;
        if (rd !== p) begin bad++; $display("FAIL abort_no_commit got=%h exp=%h", rd, p); end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp;
        exp = model[32'h12];
        mem_address = 14'h0012; mem_read = 1'b1;
        for (int c = 0; c < 2 * (LAT + 2); c++) begin
            @(negedge clk);
            total++;
            if (mem_busywait !== ((c % (LAT + 2)) != LAT + 1)) begin
                bad++; $display("FAIL b2b_busy cycle %0d got=%b", c, mem_busywait);
            end
            if ((c % (LAT + 2)) == LAT + 1) begin
                total++;
                if (mem_readdata !== exp) begin bad++; $display("FAIL b2b_rdata cycle %0d got=%h exp=%h", c, mem_readdata, exp); end
            end
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        last_rd = exp;
    endtask

    task automatic test_random();
        int busy; logic [LW-1:0] rd; logic [LW-1:0] d;
        logic [AW-1:0] pool [6];
        bit wr;
        for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            a = pool[$urandom_range(0, 5)];
            wr = !model.exists(int'(a)) || ($urandom_range(0, 1) == 1);
            d = rnd_line();
            if (wr) begin
                xfer(1'b1, 1'b0, a, d, busy, rd);
                total++;
                if (rd !== last_rd) begin bad++; $display("FAIL rnd_write_rdata n=%0d got=%h exp=%h", n, rd, last_rd); end
            end else begin
                xfer(1'b0, 1'b0, a, '0, busy, rd);
                total++;
                if (rd !== model[int'(a)]) begin bad++; $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h", n, a, rd, model[int'(a)]); end
            end
            total++;
            if (busy !== LAT + 1) begin bad++; $display("FAIL rnd_busy n=%0d got=%0d exp=%0d", n, busy, LAT + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both_top();
        test_latch();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
